// File: rtl/tnn_xnor_seq_par_pkg.sv
// Shared constants and helpers for the tnnseq XNOR/popcount layers:
// width derivations and the sequencer state encoding.
package tnn_xnor_seq_par_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Accumulator width: must hold the full count 0..N.
  function automatic int sum_len(input int n);
    return clog2(n + 1);
  endfunction

  function automatic int num_chunks(input int n, input int p);
    return ceil_div(n, p);
  endfunction

  function automatic int chunk_idx_w(input int n, input int p);
    int w;
    w = clog2(ceil_div(n, p));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tnn_xnor_seq_par_if.sv
// Start/busy/done handshake plus data and result bus of the XNOR layer.
interface tnn_xnor_seq_par_if
  import tnn_xnor_seq_par_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
);
  localparam int SUML = sum_len(N);

  logic              start;
  logic [N-1:0]      data;
  logic              busy;
  logic              done;
  logic [M*SUML-1:0] sums;
  logic [M-1:0]      out;

  modport master (output start, data, input busy, done, sums, out);
  modport slave  (input start, data, output busy, done, sums, out);

endinterface

// File: rtl/tnn_chunk_accum.sv
// One neuron: masked XNOR popcount of the selected P-bit chunk, accumulated
// over successive chunks. Lanes beyond N are padded with zero matches.
module tnn_chunk_accum
  import tnn_xnor_seq_par_pkg::*;
#(
  parameter int          N   = 8,
  parameter int          P   = 2,
  parameter logic [N-1:0] WGT = '0,
  parameter logic [N-1:0] MSK = '1,
  localparam int SUML = sum_len(N),
  localparam int NCH  = num_chunks(N, P),
  localparam int CIW  = chunk_idx_w(N, P)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_data_q,
  input  logic [CIW-1:0]  i_chunk,
  input  logic            i_clear,
  input  logic            i_en,
  output logic [SUML-1:0] o_acc,
  output logic [SUML-1:0] o_acc_nxt
);

  logic [NCH*P-1:0] w_match;
  logic [SUML-1:0]  w_cnt;
  logic [SUML-1:0]  r_acc;

  always_comb begin
    w_match = '0;
    w_match[N-1:0] = MSK & ~(i_data_q ^ WGT);
  end

  // Chunk select is a constant-index mux so padded lanes stay provably zero.
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (i_chunk == CIW'(k)) begin
        for (int l = 0; l < P; l++) begin
          w_cnt = w_cnt + SUML'(w_match[k*P+l]);
        end
      end
    end
  end

  assign o_acc_nxt = r_acc + w_cnt;
  assign o_acc     = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_acc_nxt;
    end
  end

endmodule

// File: rtl/tnn_xnor_seq_par.sv
// M-neuron XNOR/popcount layer processing P input bits per cycle with ternary
// weights, per-neuron threshold outputs and a start/busy/done handshake.
module tnn_xnor_seq_par
  import tnn_xnor_seq_par_pkg::*;
#(
  parameter int                     N       = 8,
  parameter int                     M       = 4,
  parameter int                     P       = 2,
  parameter logic [M*N-1:0]         WEIGHTS = '0,
  parameter logic [M*N-1:0]         MASK    = '1,
  parameter logic [M*sum_len(N)-1:0] THRESH = '0
) (
  input logic clk,
  input logic rst_n,
  tnn_xnor_seq_par_if.slave bus
);

  localparam int SUML = sum_len(N);
  localparam int NCH  = num_chunks(N, P);
  localparam int CIW  = chunk_idx_w(N, P);

  state_t            r_state;
  logic [N-1:0]      r_data_q;
  logic [CIW-1:0]    r_chunk;
  logic              r_busy;
  logic              r_done;
  logic [M-1:0]      r_out;

  logic              w_accept;
  logic              w_en;
  logic              w_last;
  logic [SUML-1:0]   w_acc     [M];
  logic [SUML-1:0]   w_acc_nxt [M];
  logic [M-1:0]      w_out_nxt;
  logic [M*SUML-1:0] w_sums;

  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_en     = (r_state == S_BUSY);
  assign w_last   = (r_chunk == CIW'(NCH - 1));

  for (genvar j = 0; j < M; j++) begin : g_neuron
    tnn_chunk_accum #(
      .N   (N),
      .P   (P),
      .WGT (WEIGHTS[j*N +: N]),
      .MSK (MASK[j*N +: N])
    ) u_accum (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_data_q  (r_data_q),
      .i_chunk   (r_chunk),
      .i_clear   (w_accept),
      .i_en      (w_en),
      .o_acc     (w_acc[j]),
      .o_acc_nxt (w_acc_nxt[j])
    );
  end

  // Compare against the value the accumulators are about to take, so out
  // is registered on the same edge that enters DONE.
  always_comb begin
    w_out_nxt = '0;
    w_sums    = '0;
    for (int j = 0; j < M; j++) begin
      w_out_nxt[j]             = (w_acc_nxt[j] >= THRESH[j*SUML +: SUML]);
      w_sums[j*SUML +: SUML]   = w_acc[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_data_q <= '0;
      r_chunk  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state  <= S_BUSY;
            r_data_q <= bus.data;
            r_chunk  <= '0;
            r_busy   <= 1'b1;
            r_out    <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_chunk <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_out   <= w_out_nxt;
          end else begin
            r_chunk <= r_chunk + CIW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sums = w_sums;
  assign bus.out  = r_out;

endmodule

// File: tb/tb_tnn_xnor_seq_par.sv
// Three layer instances (P=3, P=1, P=8) driven in lockstep and checked each
// cycle against a chunk-count model, plus hand-computed anchor values.
module tb_tnn_xnor_seq_par;

  localparam int N = 8;
  localparam int M = 4;
  localparam int SL = 4;
  localparam logic [M*N-1:0]  WEIGHTS = 32'hFF_FF_00_FF;
  localparam logic [M*N-1:0]  MASK    = 32'h1F_0F_FF_FF;
  localparam logic [M*SL-1:0] THRESH  = 16'h5505;
  localparam int PV  [3] = '{3, 1, 8};
  localparam int NCHV[3] = '{3, 8, 1};
  localparam int TH  [4] = '{5, 0, 5, 5};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [N-1:0] data = '0;

  always #5 clk = ~clk;

  tnn_xnor_seq_par_if #(.N(N), .M(M)) bus0 ();
  tnn_xnor_seq_par_if #(.N(N), .M(M)) bus1 ();
  tnn_xnor_seq_par_if #(.N(N), .M(M)) bus2 ();

  assign bus0.start = start; assign bus0.data = data;
  assign bus1.start = start; assign bus1.data = data;
  assign bus2.start = start; assign bus2.data = data;

  tnn_xnor_seq_par #(.N(N), .M(M), .P(3), .WEIGHTS(WEIGHTS), .MASK(MASK), .THRESH(THRESH))
    u_p3 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  tnn_xnor_seq_par #(.N(N), .M(M), .P(1), .WEIGHTS(WEIGHTS), .MASK(MASK), .THRESH(THRESH))
    u_p1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  tnn_xnor_seq_par #(.N(N), .M(M), .P(8), .WEIGHTS(WEIGHTS), .MASK(MASK), .THRESH(THRESH))
    u_p8 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic          busy_a [3];
  logic          done_a [3];
  logic [M*SL-1:0] sums_a [3];
  logic [M-1:0]  out_a  [3];

  assign busy_a[0] = bus0.busy; assign done_a[0] = bus0.done;
  assign sums_a[0] = bus0.sums; assign out_a[0]  = bus0.out;
  assign busy_a[1] = bus1.busy; assign done_a[1] = bus1.done;
  assign sums_a[1] = bus1.sums; assign out_a[1]  = bus1.out;
  assign busy_a[2] = bus2.busy; assign done_a[2] = bus2.done;
  assign sums_a[2] = bus2.sums; assign out_a[2]  = bus2.out;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Matches of neuron j over input bits i < lim.
  function automatic int pc(input int j, input logic [N-1:0] d, input int lim);
    int s;
    s = 0;
    for (int i = 0; i < N && i < lim; i++)
      if (MASK[j*N+i] && (d[i] == WEIGHTS[j*N+i])) s++;
    return s;
  endfunction

  // Model: rem = busy cycles still to come; chunks finished = NCH - rem.
  int            rem   [3];
  logic          mdone [3];
  logic [N-1:0]  cap   [3];
  logic [M*SL-1:0] esums [3];
  logic [M-1:0]  eout  [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        rem[i] = 0; mdone[i] = 1'b0; cap[i] = '0; esums[i] = '0; eout[i] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0 && start) begin
          cap[i] = data; rem[i] = NCHV[i]; mdone[i] = 1'b0; esums[i] = '0; eout[i] = '0;
        end else if (rem[i] > 0) begin
          rem[i]--;
          mdone[i] = (rem[i] == 0);
          for (int j = 0; j < M; j++) begin
            int s;
            s = pc(j, cap[i], (NCHV[i] - rem[i]) * PV[i]);
            esums[i][j*SL +: SL] = SL'(s);
            if (rem[i] == 0) eout[i][j] = (s >= TH[j]);
          end
        end else begin
          mdone[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy[p%0d]", PV[i]), 32'(busy_a[i]), 32'(rem[i] > 0));
      check($sformatf("done[p%0d]", PV[i]), 32'(done_a[i]), 32'(mdone[i]));
      check($sformatf("sums[p%0d]", PV[i]), 32'(sums_a[i]), 32'(esums[i]));
      check($sformatf("out[p%0d]",  PV[i]), 32'(out_a[i]),  32'(eout[i]));
    end
  end

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #2 start = 1'b0;
    end
  endtask

  // One run from idle; data flips after capture. Checks latency and final values.
  task automatic directed(input logic [N-1:0] d, input logic [15:0] es, input logic [3:0] eo);
    int lat [3];
    lat = '{0, 0, 0};
    @(posedge clk); #2 start = 1'b1; data = d;
    @(posedge clk); #2 start = 1'b0; data = ~d;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done_a[i] && lat[i] == 0) begin
          lat[i] = c;
          check($sformatf("lit_sums[p%0d]", PV[i]), 32'(sums_a[i]), 32'(es));
          check($sformatf("lit_out[p%0d]",  PV[i]), 32'(out_a[i]),  32'(eo));
        end
      end
    end
    check("lat_p3", lat[0], 4);
    check("lat_p1", lat[1], 9);
    check("lat_p8", lat[2], 2);
  endtask

  initial begin
    int seen;
    int c;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a[0]), 0);
    check("rst_done", 32'(done_a[0]), 0);
    check("rst_sums", 32'(sums_a[0]), 0);
    check("rst_out",  32'(out_a[0]),  0);
    @(posedge clk); #2 rst_n = 1'b1;
    idle_cycles(2);

    directed(8'hFF, 16'h5408, 4'b1011);
    idle_cycles(4);
    directed(8'h00, 16'h0080, 4'b0010);
    idle_cycles(4);

    // Back-to-back restart from DONE, with a start pulse ignored mid-run.
    @(posedge clk); #2 start = 1'b1; data = 8'hFF;
    @(posedge clk); #2 start = 1'b0;
    c = 0;
    while (!done_a[0] && c < 20) begin @(negedge clk); c++; end
    check("b2b_first_done", 32'(done_a[0]), 1);
    start = 1'b1; data = 8'h00;
    @(posedge clk); #2 start = 1'b0; data = 8'hFF;
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) check("b2b_sums_clear", 32'(sums_a[0]), 0);
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (done_a[0] && seen == 0) begin
        seen = k;
        check("b2b_sums", 32'(sums_a[0]), 32'h0080);
      end
    end
    check("b2b_lat", seen, 4);
    idle_cycles(12);

    // Asynchronous reset in the second BUSY cycle: no done pulse may follow.
    @(posedge clk); #2 start = 1'b1; data = 8'hFF;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a[0]), 0);
    check("mid_rst_sums", 32'(sums_a[0]), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_a[0] || done_a[1]) seen++;
    end
    check("mid_rst_no_done", seen, 0);

    // Random traffic with one more asynchronous reset in the middle.
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 2) == 0);
      data  = N'($urandom);
      if (k == 200) rst_n = 1'b0;
      if (k == 201) rst_n = 1'b1;
    end
    idle_cycles(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tnn_xnor_seq_par.md
Name: tnn_xnor_seq_par

Overview:
- Parametrised successor to the bit-serial XNOR/popcount neuron layer in the tnnseq datapath.
- Consumes P input bits per cycle instead of one, and supports ternary weights through a per-weight mask (a masked weight counts as zero).
- Adds a per-neuron threshold output and a start/busy/done handshake.
- Sits between the input-vector register and the next layer; M neurons share one chunk sequencer.

Parameters:
- N, 8, input vector width (number of synapses per neuron).
- M, 4, neuron count.
- P, 2, bits processed per cycle; 1 <= P <= N; N need not be a multiple of P.
- Weights, 0, M*N bits; bit [j*N+i] is neuron j, input i; 1 = +1, 0 = -1.
- Mask, all ones, M*N bits, same layout; 1 = weight active, 0 = zero weight (excluded from the count).
- Thresh, 0, M*SumL bits; field j is the unsigned threshold of neuron j.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new evaluation; sampled only in IDLE or DONE.
- data  in  N  input vector; captured on the accepted start.
- busy  out  1  high while accumulating.
- done  out  1  one-cycle pulse: sums/out are final.
- sums  out  M*SumL  per-neuron match count, field j at [j*SumL +: SumL].
- out  out  M  out[j] = (sums_j >= Thresh_j); registered.

Behaviour:
- Derived widths and counts:
  - SumL = clog2(N+1).
  - NCH = ceil(N/P).
  - Chunk index width = max(1, clog2(NCH)).
- Reset (rst_n low, asynchronous): state=IDLE, chunk index=0, busy=0, done=0, sums=0, out=0, captured data=0. Takes effect immediately, including mid-operation; no done pulse follows.
- States and transitions:
  - IDLE: start=1 captures data into an internal register, clears all accumulators, sets chunk index=0 and goes to BUSY.
  - BUSY, one cycle per chunk k = 0..NCH-1:
    - Each neuron j adds the count of i in [k*P, k*P+P-1] with i<N, Mask[j*N+i]=1 and data_q[i]==Weights[j*N+i].
    - Lanes with i>=N (last partial chunk) contribute 0.
    - Chunk index increments each cycle. After k=NCH-1, go to DONE.
  - DONE: done=1 for exactly one cycle; out is valid in this cycle; sums hold their final value.
    - start=1 here behaves as in IDLE: capture, clear, go to BUSY (back-to-back).
    - Otherwise go to IDLE.
- Latency: start accepted on edge t → busy=1 on cycles t+1..t+NCH → done=1 on cycle t+NCH+1.
- sums and out hold their last final values in IDLE until the next accepted start. On that start they clear to 0 (visible from the following cycle).
- out is updated from the final accumulator value on the edge entering DONE.
- start while BUSY is ignored. The data port may change freely after capture.
- Accumulators are SumL bits wide and cannot overflow, since the maximum is N.
- Threshold comparison is unsigned. Thresh_j=0 gives out[j]=1 always.
- P=N degenerates to a single BUSY cycle (NCH=1); P=1 reproduces bit-serial timing plus one DONE cycle.

Decomposition:
- Shared Verilog header (included, not a module):
  - clog2/ceil-div constant functions.
  - State encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - The SumL/NCH derivation, reused by the other tnnseq layers.
- Sub-module tnn_chunk_accum, one per neuron, generated M times:
  - Parameters: the neuron's N-bit weight slice, N-bit mask slice, N, P.
  - Inputs: data_q, chunk index, clear, enable.
  - Behaviour: computes masked XNOR popcount of the selected P-bit chunk and accumulates it.
  - Output: SumL-bit acc.
- The top holds the FSM, the data capture register, the chunk counter and the threshold compare.

Test Plan:
1. Reset: hold rst_n=0 → busy=0, done=0, sums=0, out=0. Assert rst_n=0 on the 2nd BUSY cycle of a run → immediate IDLE, sums=0, no done pulse ever.
2. N=8, P=3, M=2, Weights n0=8'hFF, n1=8'h00, Mask all ones, data=8'hFF, start at edge t:
   - busy on t+1..t+3; done only at t+4.
   - sums0=8, sums1=0.
3. Ternary/partial chunk: same config, Mask n0=8'h0F, data=8'hFF → sums0=4. Data bits beyond N (chunk lane 9) never counted. data=8'h00 → sums0=0.
4. Threshold: Thresh0=5. Mask n0=8'h1F with data=8'hFF → sums0=5, out0=1. Mask n0=8'h0F → sums0=4, out0=0. Thresh1=0 → out1=1.
5. Handshake:
   - start pulses during BUSY are ignored and do not shift done.
   - data changed to 8'h00 on cycle t+1 does not change the result (sums0=8).
   - start asserted in the DONE cycle → new run, next done exactly NCH+1 cycles later; sums read 0 in the first BUSY cycle.
6. Extremes: P=1, N=8 → done at t+9. P=N=8 → done at t+2. Both give identical sums to scenario 2.
